// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes a parallel word into a framed bit stream.
//
// Frame (in transmit order): start bit (1), DATA_W data bits LSB first,
// even-parity bit (XOR of the data bits), stop bit (0).
// Each bit is held on ser_data for BIT_DIV cycles; ser_en pulses on the last
// cycle of every bit so the downstream flops capture a settled value.
//
// Ports:
//   clk       system clock, rising edge
//   arst      asynchronous active-low reset
//   tx_data   payload word, sampled only when a word is accepted
//   tx_valid  source has a word
//   tx_ready  block can accept a word (only while idle)
//   ser_data  registered serial line bit
//   ser_en    registered capture strobe, one cycle per bit
//   busy      frame in progress
//   done      one-cycle pulse on the cycle the frame completes
module serial_frame_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BIT_DIV = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_data,
  output logic              ser_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PhaseW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned IdxW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BIT_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                ser_data_q, ser_data_d;
  logic                ser_en_q, ser_en_d;
  logic                done_q, done_d;
  logic                phase_last;

  assign phase_last = (phase_q == PhaseLast);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    done_d     = 1'b0;
    ser_data_d = 1'b0;
    ser_en_d   = 1'b0;

    // Phase only runs while a frame is on the line; it wraps to 0 at every bit
    // boundary, so it is already 0 when the frame returns to idle.
    if (state_q != StIdle) begin
      phase_d = phase_last ? '0 : phase_q + PhaseW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d  = StStart;
          shift_d  = tx_data;
          parity_d = ^tx_data;
          phase_d  = '0;
          idx_d    = '0;
        end
      end
      StStart: begin
        if (phase_last) state_d = StData;
      end
      StData: begin
        if (phase_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            state_d = StParity;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (phase_last) state_d = StStop;
      end
      StStop: begin
        if (phase_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line outputs are registered, so derive them from the next state.
    unique case (state_d)
      StStart:  ser_data_d = 1'b1;
      StData:   ser_data_d = shift_d[0];
      StParity: ser_data_d = parity_d;
      default:  ser_data_d = 1'b0;
    endcase
    ser_en_d = (state_d != StIdle) && (phase_d == PhaseLast);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      ser_data_q <= 1'b0;
      ser_en_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      ser_data_q <= ser_data_d;
      ser_en_q   <= ser_en_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign ser_data = ser_data_q;
  assign ser_en   = ser_en_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: one instance with BIT_DIV=4 and
// one with BIT_DIV=1. Expected line bits are queued when a word is driven and
// popped as the strobes are observed.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst;
  logic [7:0] tx_data, tx_data1;
  logic       tx_valid, tx_valid1;
  logic       tx_ready, ser_data, ser_en, busy, done;
  logic       tx_ready1, ser_data1, ser_en1, busy1, done1;

  serial_frame_tx #(.DATA_W(8), .BIT_DIV(4)) dut (
    .clk(clk), .arst(arst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_data(ser_data), .ser_en(ser_en), .busy(busy), .done(done)
  );

  serial_frame_tx #(.DATA_W(8), .BIT_DIV(1)) dut1 (
    .clk(clk), .arst(arst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .ser_data(ser_data1), .ser_en(ser_en1), .busy(busy1),
    .done(done1)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  function automatic void push_frame(input logic [7:0] w);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 8; k++) exp_q.push_back(w[k]);
    exp_q.push_back(^w);
    exp_q.push_back(1'b0);
  endfunction

  // Returns X when nothing is queued, which can never match a driven line bit.
  function automatic logic pop_exp();
    if (exp_q.size() == 0) return 1'bx;
    return exp_q.pop_front();
  endfunction

  task automatic send(input logic [7:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    push_frame(w);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Observes one frame starting at the current negedge (first frame cycle);
  // returns at the negedge where done is seen, or after the cycle budget.
  task automatic collect(input bit sel, output int nbusy, output int nstrobe,
                         output int first_s, output int last_s, output int done_at,
                         output logic [15:0] obs);
    nbusy = 0; nstrobe = 0; first_s = -1; last_s = -1; done_at = -1; obs = '0;
    for (int i = 0; i < 200; i++) begin
      logic b, e, d, s;
      b = sel ? busy1 : busy;
      e = sel ? ser_en1 : ser_en;
      d = sel ? done1 : done;
      s = sel ? ser_data1 : ser_data;
      if (d) begin
        done_at = i;
        break;
      end
      if (b) nbusy++;
      if (e) begin
        if (first_s < 0) first_s = i;
        last_s = i;
        if (nstrobe < 16) obs[nstrobe] = s;
        nstrobe++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst = 1'b0; tx_valid = 1'b0; tx_valid1 = 1'b0; tx_data = '0; tx_data1 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready);
    end
    n_checks++;
    if ({ser_data, ser_en, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data/en/busy/done=%b expected 0000",
               {ser_data, ser_en, busy, done});
    end
    n_checks++;
    if ({tx_ready1, ser_data1, ser_en1, busy1, done1} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs_div1: got %b expected 10000",
               {tx_ready1, ser_data1, ser_en1, busy1, done1});
    end
    arst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] w);
    int nb, ns, fs, ls, da;
    logic [15:0] obs;
    logic eb;
    send(w);
    n_checks++;
    if ({tx_ready, busy, ser_data, ser_en} !== 4'b0110) begin
      n_fail++;
      $display("FAIL accept_%h: got ready/busy/data/en=%b expected 0110", w,
               {tx_ready, busy, ser_data, ser_en});
    end
    collect(1'b0, nb, ns, fs, ls, da, obs);
    n_checks++;
    if (nb !== 44) begin n_fail++; $display("FAIL busy_cycles_%h: got %0d expected 44", w, nb); end
    n_checks++;
    if (ns !== 11) begin n_fail++; $display("FAIL strobes_%h: got %0d expected 11", w, ns); end
    n_checks++;
    if (fs !== 3 || ls !== 43) begin
      n_fail++; $display("FAIL strobe_pos_%h: got first %0d last %0d expected 3 43", w, fs, ls);
    end
    n_checks++;
    if (da !== 44) begin n_fail++; $display("FAIL done_pos_%h: got %0d expected 44", w, da); end
    for (int k = 0; k < 11; k++) begin
      eb = pop_exp();
      n_checks++;
      if (obs[k] !== eb) begin
        n_fail++; $display("FAIL bit%0d_%h: got %b expected %b", k, w, obs[k], eb);
      end
    end
    n_checks++;
    if ({tx_ready, busy, ser_data, ser_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL done_cycle_%h: got ready/busy/data/en=%b expected 1000", w,
               {tx_ready, busy, ser_data, ser_en});
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_clear_%h: got %b expected 0", w, done); end
  endtask

  task automatic test_reset_mid_frame();
    int nb, ns, fs, ls, da;
    logic [15:0] obs;
    send(8'hFF);
    repeat (13) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    #2 arst = 1'b0;
    #1;
    n_checks++;
    if ({ser_data, ser_en, busy, tx_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL async_reset: got data/en/busy/ready=%b expected 0001",
               {ser_data, ser_en, busy, tx_ready});
    end
    @(negedge clk);
    arst = 1'b1;
    exp_q.delete();
    collect(1'b0, nb, ns, fs, ls, da, obs);
    n_checks++;
    if (ns !== 0 || nb !== 0 || da !== -1) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got strobes %0d busy %0d done_at %0d expected 0 0 -1",
               ns, nb, da);
    end
  endtask

  task automatic test_back_to_back();
    int nb, ns, fs, ls, da;
    logic [15:0] obs;
    logic eb;
    tx_data = 8'h81; tx_valid = 1'b1; push_frame(8'h81);
    @(negedge clk);
    tx_data = 8'h3C; push_frame(8'h3C);
    for (int f = 0; f < 2; f++) begin
      collect(1'b0, nb, ns, fs, ls, da, obs);
      n_checks++;
      if (nb !== 44 || ns !== 11 || da !== 44) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got busy %0d strobes %0d done_at %0d expected 44 11 44",
                 f, nb, ns, da);
      end
      for (int k = 0; k < 11; k++) begin
        eb = pop_exp();
        n_checks++;
        if (obs[k] !== eb) begin
          n_fail++; $display("FAIL b2b_frame%0d_bit%0d: got %b expected %b", f, k, obs[k], eb);
        end
      end
      n_checks++;
      if ({ser_data, tx_ready} !== 2'b01) begin
        n_fail++; $display("FAIL b2b_idle%0d: got data/ready=%b expected 01", f, {ser_data, tx_ready});
      end
      @(negedge clk);
      tx_valid = 1'b0;
      if (f == 0) begin
        n_checks++;
        if ({busy, ser_data} !== 2'b11) begin
          n_fail++; $display("FAIL b2b_restart: got busy/data=%b expected 11", {busy, ser_data});
        end
      end
    end
  endtask

  task automatic test_bit_div1();
    int nb, ns, fs, ls, da;
    logic [15:0] obs;
    logic eb;
    tx_data1 = 8'h01; tx_valid1 = 1'b1; push_frame(8'h01);
    @(negedge clk);
    tx_valid1 = 1'b0;
    collect(1'b1, nb, ns, fs, ls, da, obs);
    n_checks++;
    if (ns !== 11 || fs !== 0 || ls !== 10) begin
      n_fail++;
      $display("FAIL div1_strobes: got %0d (first %0d last %0d) expected 11 (0 10)", ns, fs, ls);
    end
    n_checks++;
    if (nb !== 11 || da !== 11) begin
      n_fail++; $display("FAIL div1_timing: got busy %0d done_at %0d expected 11 11", nb, da);
    end
    for (int k = 0; k < 11; k++) begin
      eb = pop_exp();
      n_checks++;
      if (obs[k] !== eb) begin
        n_fail++; $display("FAIL div1_bit%0d: got %b expected %b", k, obs[k], eb);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_reset_mid_frame();
    test_back_to_back();
    test_bit_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit side of the home-controller sensor link: serializes a parallel word into a framed bit stream for a downstream serial receiver.
- Outputs are a line bit `ser_data` and a one-cycle capture strobe `ser_en`. The receiver's D flip-flops latch `ser_data` on their clock while `ser_en` is high.
- Sits between the controller core (valid/ready word source) and the per-room receiver chain.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- BIT_DIV, 4, clock cycles per serial bit period (>=1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- arst  input  1  asynchronous active-low reset: 0 resets immediately, independent of clk.
- tx_data  input  DATA_W  payload word; sampled only on accept.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word (high only in IDLE).
- ser_data  output  1  serial line bit; registered.
- ser_en  output  1  capture strobe, one cycle per bit; registered.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (arst=0): state=IDLE, tx_ready=1, ser_data=0, ser_en=0, busy=0, done=0, all counters 0, shift register 0.
  - Reset mid-frame aborts the frame; no partial retransmit after release.
- Frame layout, fixed order:
  - start bit (1)
  - DATA_W data bits, LSB first
  - even-parity bit (XOR of all data bits)
  - stop bit (0)
  - Total DATA_W+3 bits, (DATA_W+3)*BIT_DIV cycles.
- Idle line: ser_data=0, ser_en=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1.
  - On an edge with tx_valid=1: latch tx_data into the shift register, compute and store parity, go to START.
  - After that edge: tx_ready=0, busy=1, ser_data=1.
- Bit timing:
  - Phase counter runs 0..BIT_DIV-1 within each bit; ser_data is held for the whole bit.
  - ser_en=1 exactly when phase==BIT_DIV-1 (last cycle of the bit), else 0.
  - BIT_DIV=1: ser_en is high for every frame cycle.
- Transitions (each taken on the edge that ends the current bit, i.e. phase==BIT_DIV-1):
  - START -> DATA.
  - DATA: shift right one bit per bit period; after DATA_W bits -> PARITY.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Completion:
  - The edge entering IDLE sets done=1, tx_ready=1, busy=0, ser_data=0 for that cycle.
  - done clears on the next edge.
- Back-to-back:
  - A word can be accepted in the same cycle done=1 (tx_valid high).
  - Next START begins on the following edge, giving exactly one idle line cycle between frames.
- Ignored inputs:
  - tx_valid while busy is ignored; no queuing.
  - tx_data changes after accept do not affect the frame in progress.
- Counter widths: phase counter clog2(BIT_DIV) bits (min 1); bit-index counter clog2(DATA_W) bits (min 1). No wrap artefacts.

Test Plan:
- DATA_W=8, BIT_DIV=4, send 0xA5 -> 44 cycles busy, 11 ser_en pulses.
  - Sampled bits: 1,1,0,1,0,0,1,0,1,0(parity),0(stop).
  - done high exactly one cycle after the 11th strobe edge.
- Send 0x07 -> sampled data bits 1,1,1,0,0,0,0,0; parity=1; stop=0.
- Reset mid-frame: arst=0 during the 3rd data bit of 0xFF -> outputs immediately idle (ser_data=0, ser_en=0, busy=0, tx_ready=1).
  - After release, no strobes until a new tx_valid.
- tx_valid held high with tx_data changed to 0x3C mid-frame of 0x81 -> 0x81 frame unaltered.
  - 0x3C is accepted in the done cycle; its start bit follows after one idle line cycle.
- BIT_DIV=1, send 0x01 -> ser_en high for 11 consecutive cycles.
  - ser_data sequence 1,1,0,0,0,0,0,0,0,1,0.
